// File: rtl/sr_lock_arbiter_if.sv
// Handshake bundle between the lock arbiter and its environment:
// requester request/release lines, the SR flip-flop feedback, and the
// arbiter's set/reset pulses, grant vector and status flags.
interface sr_lock_arbiter_if;
  logic [3:0] Req;
  logic [3:0] Rel;
  logic       Q_fb;
  logic       S;
  logic       R;
  logic [3:0] Grant;
  logic [1:0] Owner;
  logic       Busy;
  logic       Err;

  // Environment side: drives requests, releases and flip-flop feedback.
  modport master (
    output Req, Rel, Q_fb,
    input  S, R, Grant, Owner, Busy, Err
  );

  // Arbiter side: samples requests and feedback, drives pulses and grant.
  modport slave (
    input  Req, Rel, Q_fb,
    output S, R, Grant, Owner, Busy, Err
  );
endinterface

// File: rtl/sr_lock_arbiter.sv
// Round-robin lock arbiter for four requesters. The lock flag itself
// lives in an external SR flip-flop: the arbiter pulses S to take it,
// waits for Q_fb to confirm, grants the owner, then pulses R and waits
// for Q_fb to drop before serving the next requester. Hold time and
// flip-flop acknowledge time are both bounded; overruns pulse Err.
module sr_lock_arbiter #(
  parameter int HOLD_MAX = 16,
  parameter int ACK_MAX  = 8
) (
  input logic            Clk,
  input logic            Rst_n,
  sr_lock_arbiter_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_MAX);
  localparam int ACK_W  = $clog2(ACK_MAX);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_MAX - 1);
  localparam logic [ACK_W-1:0]  ACK_ONE   = ACK_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTING  = 2'd1,
    HELD     = 2'd2,
    CLEARING = 2'd3
  } state_t;

  state_t            state_r;
  logic [ACK_W-1:0]  ack_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [1:0]        ptr_r;
  logic [1:0]        owner_r;
  logic [3:0]        grant_r;
  logic              s_r;
  logic              r_r;
  logic              busy_r;
  logic              err_r;
  logic [1:0]        winner_s;

  // First set bit of req at or above ptr, wrapping modulo 4. The scan runs
  // from the farthest candidate down so the nearest one is written last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx  = ptr + 2'(i);
      pick = req[idx] ? idx : pick;
    end
    return pick;
  endfunction

  // Hold counter increment that sticks at its top value instead of wrapping.
  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_LAST) ? v : v + HOLD_ONE;
  endfunction

  // Round-robin winner among current requesters, starting from the pointer.
  always_comb begin
    winner_s = rr_pick(bus.Req, ptr_r);
  end

  // Lock sequencer: S/R pulse generation, ack and hold supervision, grant.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= IDLE;
      ack_cnt_r  <= '0;
      hold_cnt_r <= '0;
      ptr_r      <= 2'd0;
      owner_r    <= 2'd0;
      grant_r    <= 4'b0000;
      s_r        <= 1'b0;
      r_r        <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      // Pulses last one cycle unless a branch below re-asserts them.
      s_r   <= 1'b0;
      r_r   <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.Q_fb) begin
            // Flag left set from before (e.g. across our reset): clear it first.
            r_r       <= 1'b1;
            ack_cnt_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= CLEARING;
          end else if (bus.Req != 4'b0000) begin
            owner_r   <= winner_s;
            s_r       <= 1'b1;
            ack_cnt_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= SETTING;
          end else begin
            busy_r    <= 1'b0;
          end
        end

        SETTING: begin
          if (bus.Q_fb) begin
            grant_r    <= 4'b0001 << owner_r;
            hold_cnt_r <= '0;
            state_r    <= HELD;
          end else if (ack_cnt_r == ACK_LAST) begin
            // Flip-flop never confirmed the set: give up without granting.
            err_r     <= 1'b1;
            r_r       <= 1'b1;
            ack_cnt_r <= '0;
            state_r   <= CLEARING;
          end else begin
            ack_cnt_r <= ack_cnt_r + ACK_ONE;
          end
        end

        HELD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            // Timeout wins over a coincident release so Err is still reported.
            grant_r   <= 4'b0000;
            r_r       <= 1'b1;
            err_r     <= 1'b1;
            ack_cnt_r <= '0;
            state_r   <= CLEARING;
          end else if (bus.Rel[owner_r]) begin
            grant_r   <= 4'b0000;
            r_r       <= 1'b1;
            ack_cnt_r <= '0;
            state_r   <= CLEARING;
          end else begin
            hold_cnt_r <= hold_inc(hold_cnt_r);
          end
        end

        CLEARING: begin
          if (!bus.Q_fb) begin
            ptr_r     <= owner_r + 2'd1;
            ack_cnt_r <= '0;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end else if (ack_cnt_r == ACK_LAST) begin
            // Flag still stuck high: report and try the reset pulse again.
            err_r     <= 1'b1;
            r_r       <= 1'b1;
            ack_cnt_r <= '0;
          end else begin
            ack_cnt_r <= ack_cnt_r + ACK_ONE;
          end
        end

        default: begin
          grant_r   <= 4'b0000;
          ack_cnt_r <= '0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.S     = s_r;
  assign bus.R     = r_r;
  assign bus.Grant = grant_r;
  assign bus.Owner = owner_r;
  assign bus.Busy  = busy_r;
  assign bus.Err   = err_r;

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// Bench for sr_lock_arbiter: an external SR flip-flop model with stuck-at
// overrides, a directed vector table, multi-cycle corner sequences, and a
// randomized run checked against a timestamp-based reference model.
module tb_sr_lock_arbiter;
  localparam int HOLD_MAX = 16;
  localparam int ACK_MAX  = 8;

  logic       Clk;
  logic       Rst_n;
  logic [1:0] qmode;     // 0: flip-flop attached, 1: Q_fb stuck 0, 2: Q_fb stuck 1
  logic       ff_clr;
  logic       q_ff = 1'b0;
  int         n_checks;
  int         n_errors;

  sr_lock_arbiter_if bus();

  sr_lock_arbiter #(.HOLD_MAX(HOLD_MAX), .ACK_MAX(ACK_MAX)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External SR flip-flop holding the lock flag (not reset by the DUT).
  always @(posedge Clk) begin
    if (ff_clr)      q_ff <= 1'b0;
    else if (bus.S)  q_ff <= 1'b1;
    else if (bus.R)  q_ff <= 1'b0;
  end

  assign bus.Q_fb = (qmode == 2'd0) ? q_ff : ((qmode == 2'd1) ? 1'b0 : 1'b1);

  function automatic logic [9:0] outs();
    return {bus.S, bus.R, bus.Grant, bus.Owner, bus.Busy, bus.Err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n   = 1'b0;
    bus.Req = 4'b0000;
    bus.Rel = 4'b0000;
    qmode   = 2'd0;
    ff_clr  = 1'b1;
    step();
    step();
    ff_clr  = 1'b0;
    Rst_n   = 1'b1;
  endtask

  // ---------------- reference model (timestamp based) ----------------
  int         cyc;
  int         m_phase;   // 0 free, 1 awaiting set ack, 2 locked, 3 awaiting clear ack
  int         m_t0;      // edge at which the current phase began
  logic [1:0] m_owner;
  logic [1:0] m_ptr;
  logic [3:0] m_grant;
  logic       m_s, m_r, m_err;

  task automatic model_reset();
    m_phase = 0; m_t0 = 0; m_owner = 2'd0; m_ptr = 2'd0;
    m_grant = 4'b0000; m_s = 1'b0; m_r = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] req, input logic [3:0] rel, input logic q);
    int p;
    cyc++;
    m_s = 1'b0; m_r = 1'b0; m_err = 1'b0;
    if (m_phase == 0) begin
      if (q) begin
        m_r = 1'b1; m_phase = 3; m_t0 = cyc;
      end else if (req != 4'b0000) begin
        for (int d = 0; d < 4; d++) begin
          p = (int'(m_ptr) + d) % 4;
          if (req[p]) begin
            m_owner = 2'(p);
            break;
          end
        end
        m_s = 1'b1; m_phase = 1; m_t0 = cyc;
      end
    end else if (m_phase == 1) begin
      if (q) begin
        m_grant = 4'b0001 << m_owner; m_phase = 2; m_t0 = cyc;
      end else if (cyc - m_t0 == ACK_MAX) begin
        m_err = 1'b1; m_r = 1'b1; m_phase = 3; m_t0 = cyc;
      end
    end else if (m_phase == 2) begin
      if (cyc - m_t0 == HOLD_MAX || rel[m_owner]) begin
        m_err = (cyc - m_t0 == HOLD_MAX);
        m_r = 1'b1; m_grant = 4'b0000; m_phase = 3; m_t0 = cyc;
      end
    end else begin
      if (!q) begin
        m_ptr = 2'(int'(m_owner) + 1); m_phase = 0;
      end else if (cyc - m_t0 == ACK_MAX) begin
        m_err = 1'b1; m_r = 1'b1; m_t0 = cyc;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic [9:0] exp;   // {S, R, Grant, Owner, Busy, Err}
  } vec_t;

  function automatic vec_t mk(input logic [3:0] req, input logic [3:0] rel,
                              input logic s, input logic r, input logic [3:0] g,
                              input logic [1:0] o, input logic b, input logic e);
    vec_t v;
    v.req = req; v.rel = rel; v.exp = {s, r, g, o, b, e};
    return v;
  endfunction

  vec_t vecs[15];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    int n;
    int s_cnt;
    int r_cnt;
    logic any_grant;
    int qhold;

    n_checks = 0;
    n_errors = 0;
    ff_clr   = 1'b0;
    cyc      = 0;

    vecs[0]  = mk(4'b0100, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0);
    vecs[1]  = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0);
    vecs[2]  = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    vecs[3]  = mk(4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    vecs[4]  = mk(4'b1011, 4'b1011, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
    vecs[5]  = mk(4'b0000, 4'b0100, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1, 1'b0);
    vecs[6]  = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b1, 1'b0);
    vecs[7]  = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
    vecs[8]  = mk(4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b0);
    vecs[9]  = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b0);
    vecs[10] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
    vecs[11] = mk(4'b0000, 4'b1000, 1'b0, 1'b1, 4'b0000, 2'd3, 1'b1, 1'b0);
    vecs[12] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b1, 1'b0);
    vecs[13] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);
    vecs[14] = mk(4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0);

    // Reset state while reset is held.
    Rst_n = 1'b0; bus.Req = 4'b0000; bus.Rel = 4'b0000; qmode = 2'd0; ff_clr = 1'b1;
    #3;
    check("reset_state", 32'(outs()), 32'd0);
    do_reset();

    // Directed table: single lock, non-owner release ignored, pointer advance.
    for (int i = 0; i < 15; i++) begin
      bus.Req = vecs[i].req;
      bus.Rel = vecs[i].rel;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Round-robin order 0,1,2,3,0 with one S and one R per lock.
    do_reset();
    bus.Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      s_cnt = 0; r_cnt = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        s_cnt += int'(bus.S); r_cnt += int'(bus.R);
        if (bus.Grant != 4'b0000) break;
      end
      check($sformatf("rr_grant%0d", k), 32'(bus.Grant), 32'(4'b0001 << (k % 4)));
      for (int i = 0; i < 2; i++) begin
        step();
        s_cnt += int'(bus.S); r_cnt += int'(bus.R);
      end
      bus.Rel = 4'b1111;
      step();
      s_cnt += int'(bus.S); r_cnt += int'(bus.R);
      bus.Rel = 4'b0000;
      for (int i = 0; i < 20; i++) begin
        if (bus.Busy == 1'b0) break;
        step();
        s_cnt += int'(bus.S); r_cnt += int'(bus.R);
      end
      check($sformatf("rr_idle%0d", k), 32'(bus.Busy), 32'd0);
      check($sformatf("rr_s_pulses%0d", k), 32'(s_cnt), 32'd1);
      check($sformatf("rr_r_pulses%0d", k), 32'(r_cnt), 32'd1);
    end

    // Hold timeout coinciding with the owner's release.
    do_reset();
    bus.Req = 4'b0001;
    step();
    bus.Req = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.Grant != 4'b0000) break;
    end
    check("hold_grant", 32'(bus.Grant), 32'(4'b0001));
    held = 1;
    for (int j = 1; j < HOLD_MAX; j++) begin
      step();
      held += (bus.Grant == 4'b0001) ? 1 : 0;
    end
    check("hold_len", 32'(held), 32'(HOLD_MAX));
    bus.Rel = 4'b0001;
    step();
    check("hold_timeout", 32'({bus.Grant, bus.R, bus.Err}), 32'({4'b0000, 1'b1, 1'b1}));
    bus.Rel = 4'b0000;
    step();
    check("err_one_cycle", 32'(bus.Err), 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (bus.Busy == 1'b0) break;
      step();
    end
    bus.Req = 4'b1111;
    step();
    check("next_owner", 32'({bus.S, bus.Owner}), 32'({1'b1, 2'd1}));

    // Set acknowledge timeout with Q_fb tied low.
    do_reset();
    qmode = 2'd1;
    bus.Req = 4'b0010;
    step();
    check("ack_s_pulse", 32'(bus.S), 32'd1);
    bus.Req = 4'b0000;
    n = 0; any_grant = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      any_grant = any_grant | (bus.Grant != 4'b0000);
      if (bus.Err) break;
    end
    check("ack_timeout_latency", 32'(n), 32'(ACK_MAX));
    check("ack_timeout_r", 32'({bus.R, bus.Err}), 32'({1'b1, 1'b1}));
    step();
    check("ack_no_grant", 32'(any_grant), 32'd0);
    check("ack_return_idle", 32'({bus.Busy, bus.Err}), 32'd0);

    // Asynchronous reset mid-lock with the flag stuck high, then recovery.
    do_reset();
    bus.Req = 4'b0001;
    step();
    bus.Req = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.Grant != 4'b0000) break;
    end
    qmode = 2'd2;
    step();
    #3;
    Rst_n = 1'b0;
    #1;
    check("async_reset", 32'(outs()), 32'd0);
    #2;
    Rst_n = 1'b1;
    bus.Req = 4'b0001;
    step();
    check("stale_recovery", 32'({bus.S, bus.R, bus.Grant}), 32'({1'b0, 1'b1, 4'b0000}));
    qmode = 2'd0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.Grant != 4'b0000) break;
    end
    check("post_reset_grant", 32'(bus.Grant), 32'(4'b0001));

    // Randomized run against the reference model, with occasional resets.
    do_reset();
    model_reset();
    qhold = 0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 299) == 0) begin
        Rst_n = 1'b0;
        #1;
        check("rand_reset", 32'(outs()), 32'd0);
        model_reset();
        #1;
        Rst_n = 1'b1;
      end
      if (qhold == 0) begin
        qmode = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
        qhold = $urandom_range(5, 40);
      end else begin
        qhold--;
      end
      bus.Req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      bus.Rel = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      #1;
      model_edge(bus.Req, bus.Rel, bus.Q_fb);
      step();
      check("random", 32'(outs()),
            32'({m_s, m_r, m_grant, m_owner, (m_phase != 0), m_err}));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_lock_arbiter.md
SR_LOCK_ARBITER -- requirements
Module: sr_lock_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16, SHALL set the maximum cycles one requester may hold the lock; legal range 2..256.
REQ-002 Parameter ACK_MAX, default 8, SHALL set the maximum cycles allowed for Q_fb to follow an S or R pulse; legal range 2..16.
REQ-003 Port Clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port Rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port Req, input, 4: per-requester lock request, level-sensitive.
REQ-006 Port Rel, input, 4: per-requester release, level-sensitive.
REQ-007 Port Q_fb, input, 1: Q feedback from the external SR flip-flop that holds the lock flag.
REQ-008 Port S, output, 1: set pulse driven to the external flip-flop.
REQ-009 Port R, output, 1: reset pulse driven to the external flip-flop.
REQ-010 Port Grant, output, 4: one-hot grant, all-zero when no requester owns the lock.
REQ-011 Port Owner, output, 2: index of the current or most recent owner.
REQ-012 Port Busy, output, 1: high in every state except IDLE.
REQ-013 Port Err, output, 1: one-cycle pulse on a hold timeout or an ack timeout.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have the states IDLE, SETTING, HELD and CLEARING.
REQ-016 IDLE with Q_fb=1: assert R for one cycle, go to CLEARING, grant nothing (stale-flag recovery).
REQ-017 IDLE with Q_fb=0 and Req nonzero: select the winner round-robin, searching upward from pointer ptr modulo 4; load Owner; assert S for one cycle; go to SETTING.
REQ-018 SETTING: on the first edge that samples Q_fb=1, set Grant[Owner]=1, clear the hold counter, and go to HELD.
REQ-019 SETTING: if Q_fb is still 0 after ACK_MAX cycles, pulse Err, assert R for one cycle, and go to CLEARING without granting.
REQ-020 HELD: the hold counter SHALL increment every cycle.
REQ-021 HELD: if Rel[Owner]=1, or the counter reaches HOLD_MAX-1, clear Grant, assert R for one cycle, and go to CLEARING; the timeout case SHALL also pulse Err.
REQ-022 HELD: Rel from non-owners and all Req inputs SHALL be ignored.
REQ-023 CLEARING: on the first edge that samples Q_fb=0, set ptr=(Owner+1) mod 4 and go to IDLE.
REQ-024 CLEARING: if Q_fb is still 1 after ACK_MAX cycles, pulse Err and re-pulse R; the ack counter restarts.
REQ-025 S and R SHALL never be high in the same cycle; each pulse SHALL last exactly one cycle.
REQ-026 Grant SHALL be nonzero only in HELD.
REQ-027 Latency: Req sampled at edge k gives S=1 after edge k; with an immediate Q_fb response, Grant rises after edge k+2.
REQ-028 Simultaneous Rel[Owner] and hold timeout SHALL be treated as a timeout (Err pulses).
REQ-029 The hold counter SHALL be ceil(log2(HOLD_MAX)) bits wide and SHALL saturate, never wrap.

Reset
REQ-030 Rst_n=0 SHALL, asynchronously and at any point (including mid-HELD), force the FSM to IDLE and drive S=0, R=0, Grant=0, Owner=0, Busy=0, Err=0, ptr=0, and both counters to 0.
REQ-031 The external flip-flop is not reset by this block; after reset deasserts, REQ-016 SHALL clear any stale Q_fb=1 before the first grant.

Verification
REQ-032 Idle, Req=0100, flip-flop model attached -> S pulse one cycle; Grant=0100 and Owner=2 two edges later; Busy=1 throughout.
REQ-033 Req=1111 held, each owner releases after 3 cycles -> grant order 0,1,2,3,0; each lock cycle has exactly one S pulse and one R pulse.
REQ-034 Owner never releases, HOLD_MAX=16 -> Grant drops after 16 HELD cycles; Err and R pulse together; next owner is Owner+1.
REQ-035 Q_fb tied to 0 -> Err pulses ACK_MAX cycles after S; no Grant ever; block returns to IDLE through CLEARING.
REQ-036 Rst_n pulsed low mid-HELD with Q_fb stuck at 1 -> all outputs 0 immediately; after release, R pulses before any S or Grant.
REQ-037 Rel[Owner] and hold timeout in the same cycle -> Err=1 for one cycle; Rel=1 from a non-owner while HELD -> no effect on Grant.
